// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM encoding and geometry helpers for the associative cache
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FILL,
    S_WTHRU,
    S_RESP
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A field may legitimately be zero bits wide (SETS=1, WAYS=1); vectors still need one bit
  function automatic int nz(input int width);
    return (width < 1) ? 1 : width;
  endfunction

  function automatic int off_w(input int blk_bytes);
    return clog2(blk_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int blk_bytes, input int sets);
    return addr_w - off_w(blk_bytes) - idx_w(sets);
  endfunction

  function automatic int blk_w(input int blk_bytes);
    return 8 * blk_bytes;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set true-LRU age tracking for any power-of-2 associativity
module cache_lru
  import cache_pkg::*;
#(
  parameter int SETS = 2,
  parameter int WAYS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          touch_en,
  input  logic [nz(clog2(SETS))-1:0]    touch_set,
  input  logic [nz(clog2(WAYS))-1:0]    touch_way,
  input  logic [nz(clog2(SETS))-1:0]    lru_set,
  output logic [nz(clog2(WAYS))-1:0]    lru_way
);

  localparam int AGE_WN = nz(clog2(WAYS));
  localparam int WAY_WN = nz(clog2(WAYS));

  // Age 0 is most recently used; ages in a set are always a permutation of 0..WAYS-1
  logic [AGE_WN-1:0] age_q [SETS][WAYS];
  logic [AGE_WN-1:0] age_d [SETS][WAYS];
  logic [AGE_WN-1:0] old_age;

  // Touch: touched way becomes youngest, every way younger than it ages by one
  always_comb begin
    age_d   = age_q;
    old_age = age_q[touch_set][touch_way];
    if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[touch_set][w] < old_age) begin
          age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
        end
      end
      age_d[touch_set][touch_way] = '0;
    end
  end

  // Oldest way of the queried set
  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[lru_set][w] == AGE_WN'(WAYS - 1)) lru_way = WAY_WN'(w);
    end
  end

  // Age registers; reset order makes way 0 youngest and way WAYS-1 the first victim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_WN'(w);
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/cache_assoc_param.sv
// rtl/cache_assoc_param.sv - N-way set-associative byte cache, write-back or write-through
module cache_assoc_param
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int BLK_BYTES  = 16,
  parameter int SETS       = 2,
  parameter int WAYS       = 2,
  parameter int WRITE_BACK = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [8*BLK_BYTES-1:0]   mem_wdata,
  input  logic                     mem_ready,
  input  logic [8*BLK_BYTES-1:0]   mem_rdata
);

  localparam int  OFF_W  = off_w(BLK_BYTES);
  localparam int  IDX_W  = idx_w(SETS);
  localparam int  TAG_W  = tag_w(ADDR_W, BLK_BYTES, SETS);
  localparam int  BLK_W  = blk_w(BLK_BYTES);
  localparam int  IDX_WN = nz(IDX_W);
  localparam int  WAY_WN = nz(clog2(WAYS));
  localparam bit  WB     = (WRITE_BACK != 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic [WAY_WN-1:0]   way_q, way_d;
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]    tag_d   [SETS][WAYS];
  logic                valid_q [SETS][WAYS];
  logic                valid_d [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic                dirty_d [SETS][WAYS];
  logic [BLK_W-1:0]    data_q  [SETS][WAYS];
  logic [BLK_W-1:0]    data_d  [SETS][WAYS];

  logic [OFF_W-1:0]    req_off;
  logic [IDX_WN-1:0]   req_set;
  logic [TAG_W-1:0]    req_tag;
  logic                hit_any, free_any;
  logic [WAY_WN-1:0]   hit_way, free_way, victim_way, lru_way;
  logic                touch_en;
  logic [WAY_WN-1:0]   touch_way;
  logic [BLK_W-1:0]    src_blk, new_blk, cur_blk;
  logic [TAG_W-1:0]    mem_tag;

  assign req_off = addr_q[OFF_W-1:0];
  assign req_set = (IDX_W == 0) ? '0 : IDX_WN'(addr_q >> OFF_W);
  assign req_tag = TAG_W'(addr_q >> (OFF_W + IDX_W));

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch_en  (touch_en),
    .touch_set (req_set),
    .touch_way (touch_way),
    .lru_set   (req_set),
    .lru_way   (lru_way)
  );

  // Tag compare over the set; victim is the lowest free way, otherwise the LRU way
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    free_any = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_WN'(w);
      end
      if (!valid_q[req_set][w]) begin
        free_any = 1'b1;
        free_way = WAY_WN'(w);
      end
    end
    victim_way = free_any ? free_way : lru_way;
  end

  // Next-state logic; array updates only happen on a hit-write or a completed fill
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hit_d     = hit_q;
    way_d     = way_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    data_d    = data_q;
    touch_en  = 1'b0;
    touch_way = way_q;
    src_blk   = (state_q == S_FILL) ? mem_rdata : data_q[req_set][hit_way];
    new_blk   = src_blk;
    if (we_q) new_blk[int'(req_off)*DATA_W +: DATA_W] = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = hit_any;
        if (hit_any) begin
          way_d     = hit_way;
          touch_en  = 1'b1;
          touch_way = hit_way;
          if (we_q) begin
            data_d[req_set][hit_way]  = new_blk;
            dirty_d[req_set][hit_way] = WB;
            state_d = WB ? S_RESP : S_WTHRU;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          way_d   = victim_way;
          state_d = (WB && valid_q[req_set][victim_way] && dirty_q[req_set][victim_way])
                    ? S_EVICT : S_FILL;
        end
      end
      S_EVICT: begin
        if (mem_ready) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_ready) begin
          data_d[req_set][way_q]  = new_blk;
          tag_d[req_set][way_q]   = req_tag;
          valid_d[req_set][way_q] = 1'b1;
          dirty_d[req_set][way_q] = WB && we_q;
          touch_en  = 1'b1;
          touch_way = way_q;
          state_d   = (we_q && !WB) ? S_WTHRU : S_RESP;
        end
      end
      S_WTHRU: begin
        if (mem_ready) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cur_blk   = data_q[req_set][way_q];
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_hit   = rsp_valid && hit_q;
  assign rsp_rdata = (rsp_valid && !we_q) ? cur_blk[int'(req_off)*DATA_W +: DATA_W] : '0;
  assign mem_req   = (state_q == S_EVICT) || (state_q == S_FILL) || (state_q == S_WTHRU);
  assign mem_we    = (state_q == S_EVICT) || (state_q == S_WTHRU);
  assign mem_tag   = (state_q == S_EVICT) ? tag_q[req_set][way_q] : req_tag;
  assign mem_addr  = mem_req ? ((ADDR_W'(mem_tag) << (OFF_W + IDX_W)) |
                                (ADDR_W'(req_set) << OFF_W)) : '0;
  assign mem_wdata = mem_we ? cur_blk : '0;

  // State and array registers; reset drops any in-flight miss and invalidates every line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          data_q[s][w]  <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      data_q  <= data_d;
    end
  end

endmodule
